// File: rtl/uc_pkg.sv
// uc_pkg: shared state encoding, opcode/ALU constants, instruction classes and the registered control bundle
// for the multicycle control unit.
package uc_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, PCUPD} state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BR, CLS_JAL, CLS_AUIPC, CLS_ILL
    } inst_cls_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_CMD_R     = 4'b0000;
    localparam logic [3:0] ALU_CMD_I     = 4'b0001;
    localparam logic [3:0] ALU_CMD_ST    = 4'b0010;
    localparam logic [3:0] ALU_CMD_BR    = 4'b0011;
    localparam logic [3:0] ALU_CMD_AUIPC = 4'b0100;
    localparam logic [3:0] ALU_CMD_JAL   = 4'b0101;

    typedef struct packed {
        logic       i_mem_req;
        logic       d_mem_req;
        logic       d_mem_we;
        logic       pc_en;
        logic       pc_src;
        logic       rf_we;
        logic       rf_src;
        logic       alu_src;
        logic [3:0] alu_cmd;
    } ctrl_t;

    function automatic inst_cls_t decode_op(input logic [6:0] op);
        case (op)
            OP_R:     return CLS_R;
            OP_I:     return CLS_I;
            OP_LD:    return CLS_LD;
            OP_ST:    return CLS_ST;
            OP_BR:    return CLS_BR;
            OP_JAL:   return CLS_JAL;
            OP_AUIPC: return CLS_AUIPC;
            default:  return CLS_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_cmd_of(input inst_cls_t c);
        case (c)
            CLS_I, CLS_LD: return ALU_CMD_I;
            CLS_ST:        return ALU_CMD_ST;
            CLS_BR:        return ALU_CMD_BR;
            CLS_AUIPC:     return ALU_CMD_AUIPC;
            CLS_JAL:       return ALU_CMD_JAL;
            default:       return ALU_CMD_R;
        endcase
    endfunction

    function automatic logic uses_imm(input inst_cls_t c);
        return c inside {CLS_I, CLS_LD, CLS_ST, CLS_AUIPC};
    endfunction

    function automatic logic writes_rf(input inst_cls_t c);
        return c inside {CLS_R, CLS_I, CLS_LD, CLS_AUIPC};
    endfunction

endpackage

// File: rtl/uc_wait_timer.sv
// uc_wait_timer: 8-bit wait counter shared by the fetch and data-memory waits; expired flags the
// WAIT_MAX-th waiting cycle so an ack arriving in that same cycle still wins.
module uc_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != 8'hff)
            cnt <= cnt + 8'd1;
    end

    assign expired = en && (cnt >= 8'(WAIT_MAX - 1));

endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle control unit FETCH->DECODE->EXECUTE->MEM->WB->PCUPD with registered (Moore) outputs.
// Optional UC_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int WAIT_MAX = 16
`ifdef UC_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [3:0] alu_flags,
    output logic       i_mem_req,
    input  logic       i_mem_ack,
    output logic       d_mem_req,
    input  logic       d_mem_ack,
    output logic       pc_en,
    output logic       rf_we,
    output logic       d_mem_we,
    output logic       alu_src,
    output logic       pc_src,
    output logic       rf_src,
    output logic [3:0] alu_cmd,
    output logic       mem_err
`ifdef UC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t    state_q, state_d;
    inst_cls_t cls_q, cls_d;
    ctrl_t     ctrl_q, ctrl_d;
    logic [2:0] funct3_q;
    logic taken_q, taken_d;
    logic mem_err_q, abort_q;
    logic ack_i, ack_d, expired, timeout, ex_phase;
    logic unused_flags;

    assign unused_flags = ^alu_flags[3:1];

    uc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != state_d),
        .en     (ctrl_q.i_mem_req | ctrl_q.d_mem_req),
        .expired(expired)
    );

    // Outputs are computed for the state being entered, so registered values line up with the state.
    always_comb begin
        ack_i    = ctrl_q.i_mem_req & i_mem_ack;
        ack_d    = ctrl_q.d_mem_req & d_mem_ack;
        timeout  = expired & ~ack_i & ~ack_d;
        cls_d    = state_q == DECODE ? decode_op(opcode) : state_q == PCUPD ? CLS_ILL : cls_q;
        taken_d  = state_q == EXECUTE ? ((funct3_q == 3'b000) & alu_flags[0]) | ((funct3_q == 3'b001) & ~alu_flags[0])
                                      : taken_q;
        state_d  = FETCH;
        case (state_q)
            FETCH:   state_d = ack_i ? DECODE : timeout ? PCUPD : FETCH;
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = cls_q inside {CLS_LD, CLS_ST} ? MEM : writes_rf(cls_q) ? WB : PCUPD;
            MEM:     state_d = ack_d ? (cls_q == CLS_LD ? WB : PCUPD) : timeout ? PCUPD : MEM;
            WB:      state_d = PCUPD;
            default: state_d = FETCH;
        endcase
        ex_phase         = state_d inside {EXECUTE, MEM, WB, PCUPD};
        ctrl_d           = '0;
        ctrl_d.i_mem_req = state_d == FETCH;
        ctrl_d.d_mem_req = state_d == MEM;
        ctrl_d.d_mem_we  = state_d == MEM && cls_d == CLS_ST;
        ctrl_d.rf_we     = state_d == WB;
        ctrl_d.pc_en     = state_d == PCUPD;
        ctrl_d.pc_src    = state_d == PCUPD && (cls_d == CLS_JAL || (cls_d == CLS_BR && taken_d));
        ctrl_d.rf_src    = ex_phase && cls_d == CLS_LD;
        ctrl_d.alu_src   = ex_phase && uses_imm(cls_d);
        ctrl_d.alu_cmd   = ex_phase ? alu_cmd_of(cls_d) : ALU_CMD_R;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cls_q     <= CLS_ILL;
            ctrl_q    <= '0;
            funct3_q  <= '0;
            taken_q   <= 1'b0;
            mem_err_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            ctrl_q    <= ctrl_d;
            funct3_q  <= state_q == DECODE ? funct3 : funct3_q;
            taken_q   <= taken_d;
            mem_err_q <= mem_err_q | timeout;
            abort_q   <= timeout;
        end
    end

    assign i_mem_req = ctrl_q.i_mem_req;
    assign d_mem_req = ctrl_q.d_mem_req;
    assign d_mem_we  = ctrl_q.d_mem_we;
    assign pc_en     = ctrl_q.pc_en;
    assign pc_src    = ctrl_q.pc_src;
    assign rf_we     = ctrl_q.rf_we;
    assign rf_src    = ctrl_q.rf_src;
    assign alu_src   = ctrl_q.alu_src;
    assign alu_cmd   = ctrl_q.alu_cmd;
    assign mem_err   = mem_err_q;

`ifdef UC_PERF_CNT_EN
    // abort_q marks the PC update that follows a timeout; it retires nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            instret_cnt <= instret_cnt + CNT_W'(ctrl_q.pc_en & ~abort_q);
        end
    end
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: randomized self-checking bench; a per-instruction expected cycle trace is built from the
// instruction class, fetch/data ack delays and sticky error, then compared with the DUT outputs each cycle.
module tb_uc_multiciclo;

    localparam int W = 4;
    localparam logic [12:0] HELD = 13'b0000001111110;
    localparam logic [12:0] FULL = 13'h1fff;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [3:0] alu_flags = '0;
    logic       i_mem_ack = 1'b0, d_mem_ack = 1'b0;
    logic       i_mem_req, d_mem_req, pc_en, rf_we, d_mem_we, alu_src, pc_src, rf_src, mem_err;
    logic [3:0] alu_cmd;
    logic [12:0] obs;

    int  n_checks = 0, n_errors = 0, n_instr = 0;
    bit  err_model = 1'b0;
    logic [12:0] exp_q[$], mask_q[$];
    bit iack_q[$], dack_q[$];

    always #5 clk = ~clk;

    uc_multiciclo #(.WAIT_MAX(W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .alu_flags(alu_flags),
        .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack), .d_mem_req(d_mem_req), .d_mem_ack(d_mem_ack),
        .pc_en(pc_en), .rf_we(rf_we), .d_mem_we(d_mem_we), .alu_src(alu_src), .pc_src(pc_src),
        .rf_src(rf_src), .alu_cmd(alu_cmd), .mem_err(mem_err)
    );

    assign obs = {i_mem_req, d_mem_req, d_mem_we, pc_en, pc_src, rf_we, rf_src, alu_src, alu_cmd, mem_err};

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic push(input logic [12:0] e, input logic [12:0] m, input bit ia, input bit da);
        exp_q.push_back(e);
        mask_q.push_back(m);
        iack_q.push_back(ia);
        dack_q.push_back(da);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_mem_ack = 1'b1;
        #1;
        check("rst_async", obs, 13'd0);
        err_model = 1'b0;
        @(negedge clk);
        check("rst_hold", obs, 13'd0);
        rst_n = 1'b1;
    endtask

    // fd/md: cycle (1-based) of the ack inside the wait; a value above W means no ack arrives.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic flag, input int fd,
                             input int md, input int abort_at);
        bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_au, ill, taken, to;
        logic [3:0] cmd;
        logic [12:0] h, v, hm;
        int nf, nm;
        is_r = op == 7'b0110011; is_i = op == 7'b0010011; is_ld = op == 7'b0000011;
        is_st = op == 7'b0100011; is_br = op == 7'b1100011; is_jal = op == 7'b1101111;
        is_au = op == 7'b0010111;
        ill = !(is_r | is_i | is_ld | is_st | is_br | is_jal | is_au);
        cmd = is_i | is_ld ? 4'd1 : is_st ? 4'd2 : is_br ? 4'd3 : is_au ? 4'd4 : is_jal ? 4'd5 : 4'd0;
        h = {6'b0, is_ld, is_i | is_ld | is_st | is_au, cmd, 1'b0};
        hm = ill ? ~HELD : FULL;
        taken = (f3 == 3'd0 && flag) || (f3 == 3'd1 && !flag);
        to = 1'b0;
        exp_q.delete(); mask_q.delete(); iack_q.delete(); dack_q.delete();
        nf = fd > W ? W : fd;
        for (int k = 1; k <= nf; k++)
            push({1'b1, 11'b0, err_model}, ~HELD, k == fd, 1'($urandom));
        if (fd > W) begin
            err_model = 1'b1;
            push(13'b0001000000001, ~HELD, 1'($urandom), 1'($urandom));
        end else begin
            push({12'b0, err_model}, ~HELD, 1'($urandom), 1'($urandom));
            push(h | 13'(err_model), hm, 1'($urandom), 1'($urandom));
            if (is_ld | is_st) begin
                nm = md > W ? W : md;
                for (int k = 1; k <= nm; k++)
                    push(h | 13'(err_model) | 13'h800 | (is_st ? 13'h400 : 13'h0), FULL, 1'($urandom), k == md);
                if (md > W) begin
                    err_model = 1'b1;
                    to = 1'b1;
                end
            end
            if (!to && (is_r | is_i | is_ld | is_au))
                push(h | 13'(err_model) | 13'h080, hm, 1'($urandom), 1'($urandom));
            v = h | 13'(err_model) | 13'h200 | ((!to && (is_jal || (is_br && taken))) ? 13'h100 : 13'h0);
            push(v, hm, 1'($urandom), 1'($urandom));
        end
        opcode = op; funct3 = f3; alu_flags = {3'($urandom), flag};
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            if (j == abort_at) begin
                do_reset();
                n_instr++;
                return;
            end
            check($sformatf("n%0d_op%b_c%0d", n_instr, op, j), obs & mask_q[j], exp_q[j] & mask_q[j]);
            i_mem_ack = iack_q[j];
            d_mem_ack = dack_q[j];
        end
        n_instr++;
    endtask

    initial begin
        logic [6:0] ops[7];
        logic [6:0] op;
        int sel, fd, md;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0010111};
        i_mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        run_instr(7'b0110011, 3'd0, 1'b0, 1, 1, -1);
        run_instr(7'b0000011, 3'd3, 1'b0, 2, 3, -1);
        run_instr(7'b1100011, 3'd0, 1'b1, 1, 1, -1);
        run_instr(7'b1100011, 3'd0, 1'b0, 1, 1, -1);
        run_instr(7'b1100011, 3'd1, 1'b1, 1, 1, -1);
        run_instr(7'b1100011, 3'd1, 1'b0, 3, 1, -1);
        run_instr(7'b1100011, 3'd2, 1'b1, 1, 1, -1);
        run_instr(7'b1101111, 3'd0, 1'b0, W, 1, -1);
        run_instr(7'b0010111, 3'd0, 1'b0, 1, 1, -1);
        run_instr(7'b0010011, 3'd0, 1'b0, 1, 1, -1);
        run_instr(7'b0100011, 3'd2, 1'b0, 1, W, -1);
        run_instr(7'b0100011, 3'd2, 1'b0, 1, W + 1, -1);
        run_instr(7'b0110011, 3'd0, 1'b0, 1, 1, -1);
        run_instr(7'b0010011, 3'd0, 1'b0, W + 1, 1, -1);
        run_instr(7'b0000011, 3'd3, 1'b0, 1, 3, 4);
        run_instr(7'b1111111, 3'd0, 1'b0, 1, 1, -1);
        run_instr(7'b0000011, 3'd3, 1'b0, 1, W + 1, -1);
        do_reset();
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 8);
            op = sel < 7 ? ops[sel] : sel == 7 ? 7'b1111111 : 7'($urandom);
            fd = $urandom_range(0, 9) == 0 ? W + 1 : $urandom_range(1, W);
            md = $urandom_range(0, 5) == 0 ? W + 1 : $urandom_range(1, W);
            run_instr(op, 3'($urandom), 1'($urandom), fd, md, $urandom_range(0, 30) == 0 ? 3 : -1);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
